// File: rtl/cpu_pkg.sv
// Shared definitions for the Mini-MIPS sequencer and control unit: phase encoding and opcodes.
package cpu_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6,
        StFault  = 3'd7
    } seq_state_e;

    localparam logic [5:0] OpHalt     = 6'd63;
    localparam logic [5:0] OpLw       = 6'd35;
    localparam logic [5:0] OpSw       = 6'd43;
    localparam logic [5:0] OpBeq      = 6'd41;
    localparam logic [5:0] OpBranchLo = 6'd48;
    localparam logic [5:0] OpBranchHi = 6'd54;

    function automatic logic is_branch_op(input logic [5:0] op);
        return (op == OpBeq) || ((op >= OpBranchLo) && (op <= OpBranchHi));
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/handshake bundle between the phase sequencer and the datapath, memories and decoder.
interface cpu_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             halt_req;
    logic [5:0]       op_code;
    logic             branch;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             branch_taken;
    logic             imem_ack;
    logic             dmem_ack;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             ir_we;
    logic             alu_en;
    logic             rf_we;
    logic             pc_we;
    logic             pc_src;
    logic             busy;
    logic             halted;
    logic             fault;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  start, halt_req, op_code, branch, mem_read, mem_write, reg_write,
               branch_taken, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_we, alu_en, rf_we, pc_we, pc_src,
               busy, halted, fault, state, retired
    );

    modport slave (
        output start, halt_req, op_code, branch, mem_read, mem_write, reg_write,
               branch_taken, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_we, alu_en, rf_we, pc_we, pc_src,
               busy, halted, fault, state, retired
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has waited without ack; flags the last allowed waiting cycle.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign expired = en && (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB phase sequencer with halt, memory timeout fault and
// retired-instruction counter. Outputs are decoded from the registered state and current inputs.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32,
    parameter logic [5:0]  HALT_OP = OpHalt
) (
    input logic            clk,
    input logic            rst_n,
    cpu_sequencer_if.master bus
);

    seq_state_e       state_q;
    seq_state_e       after_retire;
    logic [CNT_W-1:0] retired_q;
    logic             mem_op;
    logic             retire;
    logic             wait_en;
    logic             wait_expired;

    assign mem_op       = bus.mem_read | bus.mem_write;
    assign after_retire = bus.halt_req ? StHalt : StFetch;

    // Retire cycle is exactly the cycle the PC is committed.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            StExec:  retire = bus.branch | ~(mem_op | bus.reg_write);
            StMem:   retire = bus.dmem_ack & ~bus.mem_read;
            StWb:    retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    // The timer only runs while a request is outstanding, so any ack or phase change clears it.
    assign wait_en = ((state_q == StFetch) && !bus.imem_ack) ||
                     ((state_q == StMem) && !bus.dmem_ack);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (~wait_en),
        .en      (wait_en),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            retired_q <= '0;
        end else begin
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            case (state_q)
                StIdle: begin
                    if (bus.start) state_q <= StFetch;
                end
                StFetch: begin
                    if (bus.imem_ack) begin
                        state_q <= StDecode;
                    end else if (wait_expired) begin
                        state_q <= StFault;
                    end
                end
                StDecode: begin
                    state_q <= (bus.op_code == HALT_OP) ? StHalt : StExec;
                end
                StExec: begin
                    if (retire) begin
                        state_q <= after_retire;
                    end else if (mem_op) begin
                        state_q <= StMem;
                    end else begin
                        state_q <= StWb;
                    end
                end
                StMem: begin
                    if (bus.dmem_ack) begin
                        state_q <= bus.mem_read ? StWb : after_retire;
                    end else if (wait_expired) begin
                        state_q <= StFault;
                    end
                end
                StWb: begin
                    state_q <= after_retire;
                end
                StHalt: begin
                    if (bus.start) state_q <= StFetch;
                end
                StFault: begin
                    state_q <= StFault;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.imem_req = (state_q == StFetch);
    assign bus.ir_we    = (state_q == StFetch) && bus.imem_ack;
    assign bus.alu_en   = (state_q == StExec);
    assign bus.dmem_req = (state_q == StMem);
    // A request with both mem_read and mem_write set is treated as a load.
    assign bus.dmem_we  = (state_q == StMem) && bus.mem_write && !bus.mem_read;
    assign bus.rf_we    = (state_q == StWb);
    assign bus.pc_we    = retire;
    assign bus.pc_src   = (state_q == StExec) && bus.branch && bus.branch_taken;
    assign bus.busy     = (state_q == StFetch) || (state_q == StDecode) ||
                          (state_q == StExec) || (state_q == StMem) || (state_q == StWb);
    assign bus.halted   = (state_q == StHalt);
    assign bus.fault    = (state_q == StFault);
    assign bus.state    = state_q;
    assign bus.retired  = retired_q;

endmodule
